// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: pulses PLL areset, waits for a stable synchronized lock,
// then releases the 125 MHz domain; retries a bounded number of times before failing.
module pll_lock_ctrl #(
   parameter int ARST_CYCLES   = 16,
   parameter int STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int MAX_RETRY     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       restart,
   input  logic       pll_locked,
   output logic       pll_areset,
   output logic       domain_rst,
   output logic       pll_ok,
   output logic       pll_fail,
   output logic [3:0] retry_cnt,
   output logic [2:0] state
);

   localparam int AW = (ARST_CYCLES   > 1) ? $clog2(ARST_CYCLES)   : 1;
   localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int TW = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARST = 3'd1,
      S_WAIT = 3'd2,
      S_RUN  = 3'd3,
      S_FAIL = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, lock_s_q;
   logic [AW-1:0] arst_cnt_q, arst_cnt_d;
   logic [SW-1:0] stable_cnt_q, stable_cnt_d;
   logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
   logic [3:0]    retry_q, retry_d;
   logic          pll_areset_q, pll_areset_d;
   logic          domain_rst_q, domain_rst_d;
   logic          pll_ok_q, pll_ok_d;
   logic          pll_fail_q, pll_fail_d;
   logic          take_retry;
   logic          stable_done, timeout_done;

   assign stable_done  = lock_s_q && (stable_cnt_q == SW'(STABLE_CYCLES - 1));
   assign timeout_done = (timeout_cnt_q == TW'(LOCK_TIMEOUT - 1));

   always_comb begin
      state_d       = state_q;
      arst_cnt_d    = arst_cnt_q;
      stable_cnt_d  = stable_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      retry_d       = retry_q;
      take_retry    = 1'b0;

      if (!en) begin
         state_d = S_IDLE;
      end else if (restart && (state_q != S_IDLE)) begin
         state_d    = S_ARST;
         arst_cnt_d = '0;
         retry_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d    = S_ARST;
               arst_cnt_d = '0;
            end
            S_ARST: begin
               if (arst_cnt_q == AW'(ARST_CYCLES - 1)) begin
                  state_d       = S_WAIT;
                  stable_cnt_d  = '0;
                  timeout_cnt_d = '0;
               end else begin
                  arst_cnt_d = arst_cnt_q + AW'(1);
               end
            end
            S_WAIT: begin
               // Terminal counts always leave WAIT, so counters stop there instead of wrapping.
               if (!timeout_done) timeout_cnt_d = timeout_cnt_q + TW'(1);
               if (!lock_s_q) stable_cnt_d = '0;
               else if (!stable_done) stable_cnt_d = stable_cnt_q + SW'(1);
               if (stable_done) state_d = S_RUN;
               else if (timeout_done) take_retry = 1'b1;
            end
            S_RUN: begin
               if (!lock_s_q) take_retry = 1'b1;
            end
            S_FAIL: state_d = S_FAIL;
            default: state_d = S_IDLE;
         endcase

         if (take_retry) begin
            if (retry_q < 4'(MAX_RETRY)) begin
               retry_d    = retry_q + 4'd1;
               state_d    = S_ARST;
               arst_cnt_d = '0;
            end else begin
               state_d = S_FAIL;
            end
         end
      end

      // Outputs decoded from the next state so they register in step with state_q.
      pll_areset_d = (state_d == S_IDLE) || (state_d == S_ARST) || (state_d == S_FAIL);
      domain_rst_d = (state_d != S_RUN);
      pll_ok_d     = (state_d == S_RUN);
      pll_fail_d   = (state_d == S_FAIL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         sync1_q       <= 1'b0;
         lock_s_q      <= 1'b0;
         arst_cnt_q    <= '0;
         stable_cnt_q  <= '0;
         timeout_cnt_q <= '0;
         retry_q       <= '0;
         pll_areset_q  <= 1'b1;
         domain_rst_q  <= 1'b1;
         pll_ok_q      <= 1'b0;
         pll_fail_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= pll_locked;
         lock_s_q      <= sync1_q;
         arst_cnt_q    <= arst_cnt_d;
         stable_cnt_q  <= stable_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         retry_q       <= retry_d;
         pll_areset_q  <= pll_areset_d;
         domain_rst_q  <= domain_rst_d;
         pll_ok_q      <= pll_ok_d;
         pll_fail_q    <= pll_fail_d;
      end
   end

   assign pll_areset = pll_areset_q;
   assign domain_rst = domain_rst_q;
   assign pll_ok     = pll_ok_q;
   assign pll_fail   = pll_fail_q;
   assign retry_cnt  = retry_q;
   assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small parameters; cycle c is the value seen
// at the falling edge after the c-th rising edge following en/restart being applied.
module tb_pll_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst, en, restart, pll_locked;
   logic       pll_areset, domain_rst, pll_ok, pll_fail;
   logic [3:0] retry_cnt;
   logic [2:0] state;
   logic [10:0] obs;
   logic [10:0] exp_v;
   int n_checks = 0;
   int n_fail   = 0;

   // {state, pll_areset, domain_rst, pll_ok, pll_fail}
   localparam logic [6:0] O_IDLE = 7'b000_1100;
   localparam logic [6:0] O_ARST = 7'b001_1100;
   localparam logic [6:0] O_WAIT = 7'b010_0100;
   localparam logic [6:0] O_RUN  = 7'b011_0010;
   localparam logic [6:0] O_FAIL = 7'b100_1101;

   pll_lock_ctrl #(
      .ARST_CYCLES(4), .STABLE_CYCLES(8), .LOCK_TIMEOUT(32), .MAX_RETRY(2)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .restart(restart), .pll_locked(pll_locked),
      .pll_areset(pll_areset), .domain_rst(domain_rst), .pll_ok(pll_ok),
      .pll_fail(pll_fail), .retry_cnt(retry_cnt), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {state, pll_areset, domain_rst, pll_ok, pll_fail, retry_cnt};

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input logic lk);
      rst = 1'b1; en = 1'b0; restart = 1'b0; pll_locked = lk;
      step(2);
      exp_v = {O_IDLE, 4'd0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_state got=%b exp=%b", obs, exp_v); end
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset(1'b1);
      step(3);
      exp_v = {O_IDLE, 4'd0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL idle_en0 got=%b exp=%b", obs, exp_v); end
   endtask

   task automatic test_clean;
      do_reset(1'b1);
      en = 1'b1;
      step(1);
      exp_v = {O_ARST, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL clean_c1 got=%b exp=%b", obs, exp_v); end
      step(3);
      exp_v = {O_ARST, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL clean_c4 got=%b exp=%b", obs, exp_v); end
      step(1);
      exp_v = {O_WAIT, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL clean_c5 got=%b exp=%b", obs, exp_v); end
      step(7);
      exp_v = {O_WAIT, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL clean_c12 got=%b exp=%b", obs, exp_v); end
      step(1);
      exp_v = {O_RUN, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL clean_c13 got=%b exp=%b", obs, exp_v); end
      step(20);
      exp_v = {O_RUN, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL clean_hold got=%b exp=%b", obs, exp_v); end
   endtask

   task automatic test_no_lock;
      do_reset(1'b0);
      en = 1'b1;
      step(5);
      exp_v = {O_WAIT, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL nolock_c5 got=%b exp=%b", obs, exp_v); end
      step(31);
      exp_v = {O_WAIT, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL nolock_c36 got=%b exp=%b", obs, exp_v); end
      step(1);
      exp_v = {O_ARST, 4'd1}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL nolock_c37 got=%b exp=%b", obs, exp_v); end
      step(35);
      exp_v = {O_WAIT, 4'd1}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL nolock_c72 got=%b exp=%b", obs, exp_v); end
      step(1);
      exp_v = {O_ARST, 4'd2}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL nolock_c73 got=%b exp=%b", obs, exp_v); end
      step(35);
      exp_v = {O_WAIT, 4'd2}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL nolock_c108 got=%b exp=%b", obs, exp_v); end
      step(1);
      exp_v = {O_FAIL, 4'd2}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL nolock_c109 got=%b exp=%b", obs, exp_v); end
      step(40);
      exp_v = {O_FAIL, 4'd2}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL nolock_hold got=%b exp=%b", obs, exp_v); end
   endtask

   // Continues from the FAIL state left by test_no_lock.
   task automatic test_restart_fail;
      pll_locked = 1'b1; restart = 1'b1;
      step(1);
      restart = 1'b0;
      exp_v = {O_ARST, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL restart_c1 got=%b exp=%b", obs, exp_v); end
      step(3);
      exp_v = {O_ARST, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL restart_c4 got=%b exp=%b", obs, exp_v); end
      step(8);
      exp_v = {O_WAIT, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL restart_c12 got=%b exp=%b", obs, exp_v); end
      step(1);
      exp_v = {O_RUN, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL restart_c13 got=%b exp=%b", obs, exp_v); end
   endtask

   task automatic test_glitch;
      do_reset(1'b1);
      en = 1'b1;
      step(9);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(3);
      exp_v = {O_WAIT, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL glitch_c13 got=%b exp=%b", obs, exp_v); end
      step(6);
      exp_v = {O_WAIT, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL glitch_c19 got=%b exp=%b", obs, exp_v); end
      step(1);
      exp_v = {O_RUN, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL glitch_c20 got=%b exp=%b", obs, exp_v); end
   endtask

   task automatic test_lock_loss;
      do_reset(1'b1);
      en = 1'b1;
      step(18);
      exp_v = {O_RUN, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL loss_pre got=%b exp=%b", obs, exp_v); end
      pll_locked = 1'b0;
      step(3);
      exp_v = {O_ARST, 4'd1}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL loss_t3 got=%b exp=%b", obs, exp_v); end
      pll_locked = 1'b1;
      step(12);
      exp_v = {O_RUN, 4'd1}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL loss_rerun got=%b exp=%b", obs, exp_v); end
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      exp_v = {O_ARST, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL restart_run got=%b exp=%b", obs, exp_v); end
   endtask

   task automatic test_en_off;
      do_reset(1'b0);
      en = 1'b1;
      step(45);
      exp_v = {O_WAIT, 4'd1}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL enoff_wait got=%b exp=%b", obs, exp_v); end
      en = 1'b0;
      step(1);
      exp_v = {O_IDLE, 4'd1}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL enoff_idle got=%b exp=%b", obs, exp_v); end
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      step(4);
      exp_v = {O_IDLE, 4'd1}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL enoff_hold got=%b exp=%b", obs, exp_v); end
      en = 1'b1;
      step(1);
      exp_v = {O_ARST, 4'd1}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL enon_arst got=%b exp=%b", obs, exp_v); end
      step(6);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      exp_v = {O_IDLE, 4'd0}; n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL midrst got=%b exp=%b", obs, exp_v); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; restart = 1'b0; pll_locked = 1'b0;
      @(negedge clk);
      test_reset();
      test_clean();
      test_no_lock();
      test_restart_fail();
      test_glitch();
      test_lock_loss();
      test_en_off();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter ARST_CYCLES, default 16, PLL areset pulse length in clk cycles (min 1).
REQ-002 Parameter STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before release (min 1).
REQ-003 Parameter LOCK_TIMEOUT, default 50000, WAIT cycles allowed per attempt, 1 ms at 50 MHz (must be > STABLE_CYCLES).
REQ-004 Parameter MAX_RETRY, default 3, retries allowed after the first attempt (0..15).
REQ-005 clk  input  1  50 MHz reference clock, the same net that drives PLL inclk0; all logic on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  level; 1 = bring up and hold the 125 MHz domain, 0 = park.
REQ-008 restart  input  1  one-cycle pulse; forces a fresh bring-up and clears the retry count.
REQ-009 pll_locked  input  1  PLL locked output, asynchronous to clk.
REQ-010 pll_areset  output  1  PLL areset drive, active high.
REQ-011 domain_rst  output  1  reset request for 125 MHz-domain logic, active high; the consumer re-synchronizes it.
REQ-012 pll_ok  output  1  1 only in RUN.
REQ-013 pll_fail  output  1  1 only in FAIL.
REQ-014 retry_cnt  output  4  retries consumed since last rst/restart.
REQ-015 state  output  3  IDLE=0, ARST=1, WAIT=2, RUN=3, FAIL=4.

Function
REQ-016 pll_locked SHALL pass through a 2-flop synchronizer; lock_s denotes the second-flop output; all decisions use lock_s only.
REQ-017 All outputs SHALL be registered and decoded from the state register: pll_areset=1 in IDLE/ARST/FAIL; domain_rst=0 only in RUN.
REQ-018 IDLE: en=1 SHALL move to ARST on the next cycle with the areset counter cleared.
REQ-019 ARST: SHALL remain exactly ARST_CYCLES cycles, then move to WAIT with the stable and timeout counters cleared.
REQ-020 WAIT: the timeout counter SHALL increment every cycle; the stable counter SHALL increment when lock_s=1 and clear to 0 when lock_s=0.
REQ-021 WAIT: the cycle on which lock_s=1 and the stable counter equals STABLE_CYCLES-1 SHALL move to RUN.
REQ-022 WAIT: the timeout counter reaching LOCK_TIMEOUT-1 without REQ-021 SHALL take the retry path; when both coincide, RUN wins.
REQ-023 Retry path: if retry_cnt < MAX_RETRY, increment retry_cnt and go to ARST; otherwise go to FAIL with retry_cnt unchanged.
REQ-024 RUN: lock_s=0 SHALL take the retry path; retry_cnt is not cleared on entering RUN.
REQ-025 FAIL: SHALL be held until restart, en=0 or rst.
REQ-026 restart=1 in any state except IDLE SHALL go to ARST next cycle with retry_cnt=0; restart in IDLE is ignored.
REQ-027 en=0 in any state SHALL go to IDLE next cycle, preserving retry_cnt.
REQ-028 Priority SHALL be rst > en=0 > restart > normal transitions.
REQ-029 Counters SHALL be sized to the parameters (clog2) and SHALL never wrap, since every terminal value forces a state exit.

Reset
REQ-030 rst=1 SHALL set state=IDLE, pll_areset=1, domain_rst=1, pll_ok=0, pll_fail=0, retry_cnt=0, all counters and both synchronizer flops to 0 on the next edge.
REQ-031 rst mid-operation (any state) SHALL behave identically to REQ-030; there are no partial-reset paths.

Verification (bench parameters ARST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRY=2)
REQ-032 Clean bring-up: en=1 from cycle 0, pll_locked=1 constant -> state=1 at cycles 1-4, pll_areset=0 from cycle 5, pll_ok=1 and domain_rst=0 at cycle 13, retry_cnt=0.
REQ-033 No lock: pll_locked=0 forever -> three ARST+WAIT attempts, retry_cnt steps 0->1->2, then state=4, pll_fail=1, pll_areset=1 held, retry_cnt=2.
REQ-034 Lock glitch in WAIT: pll_locked low for 1 cycle after 5 stable cycles -> stable count restarts, RUN entered 8 lock_s-high cycles after the glitch clears, no retry consumed.
REQ-035 Lock loss in RUN: pll_locked falls at cycle T -> domain_rst=1, pll_ok=0 by T+3, state=1, retry_cnt incremented by 1.
REQ-036 en=0 mid-WAIT -> state=0 next cycle, pll_areset=1, domain_rst=1, retry_cnt retained.
REQ-037 restart pulse in FAIL -> state=1 next cycle, pll_fail=0, retry_cnt=0, then a normal bring-up per REQ-032 timing.
